// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings for the byte-lane data memory: access size
//               codes and the access-sequencing state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size encodings carried on the `size` port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Access sequencer states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } dmem_state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational little-endian lane steering for the data
//               memory. Store side: byte enables and data replication.
//               Load side: lane extract with sign/zero extension. Also flags
//               misaligned and illegal-size accesses.
// Ports       : i_size      - access size (byte/half/word/illegal)
//               i_sext      - 1 = sign-extend loads, 0 = zero-extend
//               i_addr_lo   - byte offset within the word
//               i_wdata     - right-justified store data
//               i_rword     - full word read from the array
//               o_be        - per-byte write enables
//               o_wdata_rep - store data replicated onto every lane
//               o_rdata_ext - right-justified, extended load result
//               o_misalign  - size/offset combination is not legal
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_ext,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side. Replicating the data onto every lane lets the byte enables
    // alone decide which lanes land, so no per-lane shifter is needed.
    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
        o_misalign  = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_misalign  = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_be       = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

    // Load side lane extract
    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_rdata_ext = i_rword;
        case (i_size)
            SZ_BYTE: o_rdata_ext = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata_ext = {{16{i_sext & w_half[15]}}, w_half};
            default: o_rdata_ext = i_rword;
        endcase
    end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bytelane
// Description : Synchronous byte/half/word data memory with a req/ready/done
//               handshake and configurable access latency. Faulting accesses
//               (misaligned, illegal size, out of range) raise err and leave
//               both the array and rdata untouched.
// Ports       : clk, rst_n - clock, asynchronous active-low reset
//               req        - access request, taken when ready is high
//               we         - 1 = store, 0 = load
//               size       - 00 byte, 01 half, 10 word, 11 illegal
//               sext       - load sign-extend select
//               addr       - byte address
//               wdata      - right-justified store data
//               ready      - a request can be accepted this cycle
//               done       - one-cycle completion pulse
//               err        - access faulted (valid with done)
//               rdata      - load result (valid with done on good loads)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int          c_AW         = $clog2(DEPTH);
    localparam dmem_state_t c_ACCEPT_NXT = (LATENCY == 1) ? S_DONE : S_BUSY;

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;

    logic        w_ready;
    logic        w_done;
    logic        w_accept;
    logic        w_access;    // the edge on which the array is read/written
    logic        w_cnt_zero;

    // Operands of the access being performed on the w_access edge
    logic        w_op_we;
    logic [1:0]  w_op_size;
    logic        w_op_sext;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;

    logic [3:0]      w_be;
    logic [31:0]     w_wdata_rep;
    logic [31:0]     w_rword;
    logic [31:0]     w_rdata_ext;
    logic            w_misalign;
    logic            w_oob;
    logic            w_fault;
    logic [c_AW-1:0] w_idx;

    logic            r_err;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH];

    assign w_accept = req & w_ready;

    // ------------------------------------------------------------------
    // Latency-dependent operand path and countdown
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_lat_one
            // The accept edge is also the edge that enters DONE, so the
            // access works straight from the request inputs.
            assign w_op_we    = we;
            assign w_op_size  = size;
            assign w_op_sext  = sext;
            assign w_op_addr  = addr;
            assign w_op_wdata = wdata;
            assign w_cnt_zero = 1'b1;
            assign w_access   = w_accept & rst_n;
        end else begin : g_lat_multi
            localparam int c_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
            localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 2);

            logic [c_CNT_W-1:0] r_cnt;
            logic               r_we;
            logic [1:0]         r_size;
            logic               r_sext;
            logic [31:0]        r_addr;
            logic [31:0]        r_wdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_we    <= 1'b0;
                    r_size  <= SZ_BYTE;
                    r_sext  <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                end else if (w_accept) begin
                    r_cnt   <= c_CNT_LOAD;
                    r_we    <= we;
                    r_size  <= size;
                    r_sext  <= sext;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                end else if (r_state == S_BUSY && r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_op_we    = r_we;
            assign w_op_size  = r_size;
            assign w_op_sext  = r_sext;
            assign w_op_addr  = r_addr;
            assign w_op_wdata = r_wdata;
            assign w_cnt_zero = (r_cnt == '0);
            assign w_access   = (r_state == S_BUSY) & w_cnt_zero;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register / next state / output decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = w_accept ? c_ACCEPT_NXT : S_IDLE;
            S_BUSY:         w_state_nxt = w_cnt_zero ? S_DONE : S_BUSY;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state != S_BUSY);
        w_done  = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Lane steering and fault detection
    // ------------------------------------------------------------------
    dmem_lane_align u_align (
        .i_size      (w_op_size),
        .i_sext      (w_op_sext),
        .i_addr_lo   (w_op_addr[1:0]),
        .i_wdata     (w_op_wdata),
        .i_rword     (w_rword),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext),
        .o_misalign  (w_misalign)
    );

    assign w_idx   = w_op_addr[c_AW+1:2];
    assign w_oob   = |w_op_addr[31:c_AW+2];
    assign w_fault = w_misalign | w_oob;
    assign w_rword = r_mem[w_idx];

    // ------------------------------------------------------------------
    // Array: no reset so it maps onto RAM; byte-enable write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_access && w_op_we && !w_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata_rep[8*k +: 8];
                end
            end
        end
    end

    // Completion status and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_access) begin
            r_err <= w_fault;
            if (!w_op_we && !w_fault) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    assign ready = w_ready;
    assign done  = w_done;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule : dmem_bytelane
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bytelane
// Description : Directed self-checking bench. Three instances share the clock
//               and reset: LATENCY 1, 3 and 4 (DEPTH 512 each).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_v, we_v, sext_v;
    logic [1:0]  size_a  [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic [2:0]  ready_v, done_v, err_v;
    logic [31:0] rdata_a [3];

    int n_total = 0;
    int n_bad   = 0;
    int lat_of [3] = '{1, 3, 4};

    // Back-to-back stream for the LATENCY=3 instance
    logic        s_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] s_addr [4] = '{32'h30, 32'h30, 32'h34, 32'h34};
    logic [31:0] s_wd   [4] = '{32'hCAFEBABE, 32'h0, 32'h13579BDF, 32'h0};

    dmem_bytelane #(.DEPTH(512), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_v[0]), .size(size_a[0]),
        .sext(sext_v[0]), .addr(addr_a[0]), .wdata(wdata_a[0]), .ready(ready_v[0]),
        .done(done_v[0]), .err(err_v[0]), .rdata(rdata_a[0]));

    dmem_bytelane #(.DEPTH(512), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_v[1]), .size(size_a[1]),
        .sext(sext_v[1]), .addr(addr_a[1]), .wdata(wdata_a[1]), .ready(ready_v[1]),
        .done(done_v[1]), .err(err_v[1]), .rdata(rdata_a[1]));

    dmem_bytelane #(.DEPTH(512), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we_v[2]), .size(size_a[2]),
        .sext(sext_v[2]), .addr(addr_a[2]), .wdata(wdata_a[2]), .ready(ready_v[2]),
        .done(done_v[2]), .err(err_v[2]), .rdata(rdata_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access on instance i, checking done, latency, err and
    // optionally rdata.
    task automatic run(input int i, input string tag, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
        int n;
        @(negedge clk);
        req_v[i] = 1'b1; we_v[i] = w; size_a[i] = sz; sext_v[i] = sx;
        addr_a[i] = a; wdata_a[i] = wd;
        n = 0;
        while (!ready_v[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_v[i] = 1'b0;
        n = 1;
        while (!done_v[i] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "/done"}, done_v[i], 1);
        chk({tag, "/lat"}, n, lat_of[i]);
        chk({tag, "/err"}, err_v[i], exp_err);
        if (chk_rd) chk({tag, "/rdata"}, rdata_a[i], exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_v = '0; we_v = '0; sext_v = '0;
        for (int i = 0; i < 3; i++) begin
            size_a[i] = SZ_BYTE; addr_a[i] = '0; wdata_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d/ready", i), ready_v[i], 1);
            chk($sformatf("rst%0d/done", i), done_v[i], 0);
            chk($sformatf("rst%0d/err", i), err_v[i], 0);
            chk($sformatf("rst%0d/rdata", i), rdata_a[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- LATENCY = 1 ----------------
        run(0, "sw10",   1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 0, 0, 0);
        run(0, "lw10",   0, SZ_WORD, 0, 32'h10,  32'h0, 0, 1, 32'hDEADBEEF);
        run(0, "lb13s",  0, SZ_BYTE, 1, 32'h13,  32'h0, 0, 1, 32'hFFFFFFDE);
        run(0, "lb13u",  0, SZ_BYTE, 0, 32'h13,  32'h0, 0, 1, 32'h000000DE);
        run(0, "lh10s",  0, SZ_HALF, 1, 32'h10,  32'h0, 0, 1, 32'hFFFFBEEF);
        run(0, "lh12u",  0, SZ_HALF, 0, 32'h12,  32'h0, 0, 1, 32'h0000DEAD);
        run(0, "sb11",   1, SZ_BYTE, 0, 32'h11,  32'h00000055, 0, 0, 0);
        run(0, "lw10b",  0, SZ_WORD, 0, 32'h10,  32'h0, 0, 1, 32'hDEAD55EF);
        run(0, "sw20",   1, SZ_WORD, 0, 32'h20,  32'h11223344, 0, 0, 0);
        run(0, "sh21",   1, SZ_HALF, 0, 32'h21,  32'h0000AAAA, 1, 1, 32'hDEAD55EF);
        run(0, "lw20",   0, SZ_WORD, 0, 32'h20,  32'h0, 0, 1, 32'h11223344);
        run(0, "lw802",  0, SZ_WORD, 0, 32'h802, 32'h0, 1, 1, 32'h11223344);
        run(0, "lw800",  0, SZ_WORD, 0, 32'h800, 32'h0, 1, 1, 32'h11223344);
        run(0, "szill",  0, SZ_ILL,  0, 32'h20,  32'h0, 1, 1, 32'h11223344);
        run(0, "sh22",   1, SZ_HALF, 0, 32'h22,  32'h00008001, 0, 0, 0);
        run(0, "lh22s",  0, SZ_HALF, 1, 32'h22,  32'h0, 0, 1, 32'hFFFF8001);
        run(0, "lw20b",  0, SZ_WORD, 0, 32'h20,  32'h0, 0, 1, 32'h80013344);
        run(0, "sb7ff",  1, SZ_BYTE, 0, 32'h7FF, 32'h00000080, 0, 0, 0);
        run(0, "lb7ffs", 0, SZ_BYTE, 1, 32'h7FF, 32'h0, 0, 1, 32'hFFFFFF80);

        // ---------------- LATENCY = 3, req held high ----------------
        begin : l3_stream
            int   k;
            logic rdy;
            logic exp_act;
            @(negedge clk);
            k = 0;
            req_v[1] = 1'b1; we_v[1] = s_we[0]; size_a[1] = SZ_WORD; sext_v[1] = 1'b0;
            addr_a[1] = s_addr[0]; wdata_a[1] = s_wd[0];
            rdy = ready_v[1];
            for (int e = 0; e < 12; e++) begin
                @(posedge clk);
                #1;
                exp_act = (e % 3 == 2);
                chk($sformatf("l3_ready_%0d", e), ready_v[1], exp_act);
                chk($sformatf("l3_done_%0d", e), done_v[1], exp_act);
                if (exp_act) chk($sformatf("l3_err_%0d", e), err_v[1], 0);
                if (e == 5)  chk("l3_ld0", rdata_a[1], 32'hCAFEBABE);
                if (e == 11) chk("l3_ld1", rdata_a[1], 32'h13579BDF);
                if (rdy && req_v[1]) begin
                    k++;
                    if (k < 4) begin
                        we_v[1] = s_we[k]; addr_a[1] = s_addr[k]; wdata_a[1] = s_wd[k];
                    end else begin
                        req_v[1] = 1'b0;
                    end
                end
                @(negedge clk);
                rdy = ready_v[1];
            end
        end

        // ---------------- LATENCY = 4, reset mid-access ----------------
        run(2, "l4_sw40", 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0);
        run(2, "l4_lw40", 0, SZ_WORD, 0, 32'h40, 32'h0, 0, 1, 32'hCAFEF00D);
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; size_a[2] = SZ_WORD; sext_v[2] = 1'b0;
        addr_a[2] = 32'h40; wdata_a[2] = 32'h12345678;
        @(posedge clk);
        #1;
        req_v[2] = 1'b0;
        chk("l4_busy_ready", ready_v[2], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("l4_rst_done", done_v[2], 0);
        chk("l4_rst_err", err_v[2], 0);
        chk("l4_rst_rdata", rdata_a[2], 0);
        chk("l4_rst_ready", ready_v[2], 1);
        repeat (3) @(posedge clk);
        #1;
        chk("l4_rst_done2", done_v[2], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2, "l4_lw40_after", 0, SZ_WORD, 0, 32'h40, 32'h0, 0, 1, 32'hCAFEF00D);
        // LATENCY=1 array contents survive reset too
        run(0, "l1_lw10_after", 0, SZ_WORD, 0, 32'h10, 32'h0, 0, 1, 32'hDEAD55EF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_dmem_bytelane
`default_nettype wire

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised, synchronous data memory for the MEM stage of the pipelined MIPS CPU, replacing the word-only combinational data memory. It supports byte, halfword and word accesses with little-endian lane selection and sign/zero extension. A req/ready/done handshake with a configurable access latency lets the pipeline stall on slow memory. Misaligned, out-of-range and illegal-size accesses are flagged instead of corrupting state.

## Interface
- `DEPTH`, 512: number of 32-bit words. Must be a power of 2, ≥ 4.
- `LATENCY`, 1: cycles from the accept edge to `done`. Must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: access request. Sampled when `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `sext` in 1: for loads, 1 = sign-extend and 0 = zero-extend. Ignored for word accesses and stores.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified (byte in bits 7:0, half in bits 15:0).
- `ready` out 1: the block can accept a request this cycle.
- `done` out 1: one-cycle pulse marking access completion.
- `err` out 1: valid with `done`. Set if the access faulted.
- `rdata` out 32: load result, valid with `done` when `we`=0 and `err`=0. Holds its value otherwise.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `ready`=1.
  - BUSY: counts down LATENCY−1 cycles; `ready`=0.
  - DONE: `done`=1, `ready`=1.
- Accept condition: `req` & `ready`. On accept, `we`, `size`, `sext`, `addr` and `wdata` are captured.
- Next state after accept:
  - LATENCY=1: next state DONE.
  - LATENCY>1: next state BUSY, counter loaded with LATENCY−2. BUSY → DONE when the counter reaches 0.
- DONE transitions:
  - DONE with a new accept → BUSY or DONE, per the rules above (back-to-back accesses).
  - DONE otherwise → IDLE.
- Fault check is performed on the captured request. A fault means any of:
  - `size`=11;
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - `addr` ≥ DEPTH·4.
- Faulted access: `err`=1 with `done`. No array write occurs and `rdata` is unchanged.
- Word index: `addr[log2(DEPTH)+1:2]`.
- Lane mapping is little-endian:
  - byte k ↔ bits 8k+7:8k;
  - half at `addr[1]`=0 ↔ bits 15:0; half at `addr[1]`=1 ↔ bits 31:16.
- Stores:
  - Only the selected lanes are written (byte-enable write). Other lanes are preserved.
  - The write commits on the clock edge that enters DONE.
- Loads:
  - The array is read on the same edge that enters DONE.
  - The selected lane is right-justified and extended per `sext`.
- Memory contents are not reset; they are X until written. Testbenches preload them via hierarchical init.
- Only one access is outstanding at a time.
- A load accepted in the DONE cycle of a store to the same word returns the stored data, because that write has already committed.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, counter=0.
- Reset asserted mid-access: the access is abandoned and any pending write is discarded. Array contents written by earlier accesses are retained.
- Request accepted at edge t:
  - `done`/`err` are high during cycle t+LATENCY;
  - `rdata` is valid in that same cycle.
- Throughput:
  - LATENCY=1: one access per cycle when `req` is held high.
  - Otherwise: one access per LATENCY cycles.
- `req` while `ready`=0 is ignored. The requester must hold `req` and its fields until accepted.
- All outputs are registered or decode state only. There are no combinational paths from inputs to outputs.

## Structure
- Package `dmem_pkg` contains:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL;
  - the state enum (S_IDLE, S_BUSY, S_DONE).
- Sub-module `dmem_lane_align` (combinational) contains:
  - the store-side byte-enable and wdata replication;
  - the load-side lane extract and sign/zero extension;
  - the misalignment check.
- The top level holds the FSM, the latency counter, the capture registers and the array.

## Test plan
- Reset, then store word 0xDEADBEEF to addr 0x10, then load word from 0x10 → `rdata`=0xDEADBEEF, `err`=0, `done` at t+LATENCY.
- After that store:
  - load byte from 0x13 with `sext`=1 → 0xFFFFFFDE;
  - `sext`=0 → 0x000000DE;
  - load half from 0x10 with `sext`=1 → 0xFFFFBEEF.
- Store byte 0x55 to 0x11 over 0xDEADBEEF, then load word → 0xDEAD55EF (other lanes preserved).
- Faults:
  - half store at 0x21 → `err`=1, word at 0x20 unchanged;
  - word load at 0x802 with DEPTH=512 → `err`=1;
  - `size`=11 → `err`=1.
- LATENCY=3 with `req` held high for 4 back-to-back accesses:
  - `ready` low for 2 cycles after each accept;
  - `done` every 3rd cycle;
  - a load issued in a store's DONE cycle sees the new data.
- LATENCY=4: assert `rst_n`=0 one cycle after accepting a store of 0x12345678 to 0x40, release, then load 0x40 → prior contents, not 0x12345678. `done`, `err` and `rdata` are 0 during reset.
